// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the decode-stage branch logic.
//   - OP_BEQ / OP_BNE     : primary opcodes of the two conditional branches
//   - FWD_RF/EXMEM/MEMWB  : branch operand forward-select encodings
//   - NOP_INSTR           : the all-zero instruction (sll $0,$0,0)
//   - state_t             : branch FSM state encoding (IDLE / STALL)
//   - reg_match()         : true when a producer register collides with rs/rt
package mips_pkg;

    localparam logic [5:0]  OP_BEQ    = 6'b000100;
    localparam logic [5:0]  OP_BNE    = 6'b000101;

    localparam logic [1:0]  FWD_RF    = 2'b00;
    localparam logic [1:0]  FWD_EXMEM = 2'b01;
    localparam logic [1:0]  FWD_MEMWB = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    // $0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt);
        return (rd != 5'd0) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/branch_compare.sv
// branch_compare: combinational branch resolution datapath.
//   fwd_a / fwd_b        in  : operand selects (00 RF, 01 EX/MEM, 10 MEM/WB, 11 RF)
//   rf_rdata1/2          in  : register file values of rs / rt
//   exmem_alu_result     in  : EX/MEM forwarding source
//   memwb_wb_data        in  : MEM/WB forwarding source
//   is_bne               in  : 1 = bne, 0 = beq
//   pc_plus4             in  : PC+4 of the branch
//   imm                  in  : 16-bit branch offset (in words)
//   taken                out : branch condition satisfied
//   target               out : pc_plus4 + (sext(imm) << 2), wrapping
module branch_compare
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [WIDTH-1:0] rf_rdata1,
    input  logic [WIDTH-1:0] rf_rdata2,
    input  logic [WIDTH-1:0] exmem_alu_result,
    input  logic [WIDTH-1:0] memwb_wb_data,
    input  logic             is_bne,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [15:0]      imm,
    output logic             taken,
    output logic [WIDTH-1:0] target
);

    logic [1:0]       sel     [2];
    logic [WIDTH-1:0] rf_val  [2];
    logic [WIDTH-1:0] operand [2];
    logic             eq;

    assign sel[0]    = fwd_a;
    assign sel[1]    = fwd_b;
    assign rf_val[0] = rf_rdata1;
    assign rf_val[1] = rf_rdata2;

    // One identical forwarding mux per operand; the unused 11 code falls back
    // to the register file value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand_mux
            always_comb begin
                operand[gi] = rf_val[gi];
                case (sel[gi])
                    FWD_EXMEM: operand[gi] = exmem_alu_result;
                    FWD_MEMWB: operand[gi] = memwb_wb_data;
                    default:   operand[gi] = rf_val[gi];
                endcase
            end
        end
    endgenerate

    assign eq     = (operand[0] == operand[1]);
    assign taken  = is_bne ? !eq : eq;
    assign target = pc_plus4 + {{(WIDTH-18){imm[15]}}, imm, 2'b00};

endmodule

// File: rtl/id_branch_unit.sv
// id_branch_unit: ID-stage branch resolution for the 5-stage MIPS pipeline.
// Holds the IF/ID register, detects branch operand hazards that forwarding
// cannot cover yet, stalls the front end for 1 or 2 cycles, then resolves
// beq/bne in ID and redirects/flushes fetch.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   if_pc_plus4, if_instr       : IF stage outputs into IF/ID
//   ifid_pc_plus4, ifid_instr   : IF/ID register contents
//   rf_rdata1/2                 : register file reads of rs / rt
//   exmem_alu_result            : EX/MEM forward source
//   memwb_wb_data               : MEM/WB forward source
//   branch_fwd_a/b              : operand forward selects
//   idex_reg_write/mem_read/rd  : producer in ID/EX
//   exmem_mem_read/rd           : load in EX/MEM
//   pc_write, ifid_write        : front-end enables (0 while stalled)
//   idex_bubble                 : zero ID/EX control this cycle
//   branch_taken, branch_target : PC redirect
//   if_flush                    : fall-through instruction squashed
module id_branch_unit
    import mips_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STALL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] if_pc_plus4,
    input  logic [WIDTH-1:0] if_instr,
    output logic [WIDTH-1:0] ifid_pc_plus4,
    output logic [WIDTH-1:0] ifid_instr,
    input  logic [WIDTH-1:0] rf_rdata1,
    input  logic [WIDTH-1:0] rf_rdata2,
    input  logic [WIDTH-1:0] exmem_alu_result,
    input  logic [WIDTH-1:0] memwb_wb_data,
    input  logic [1:0]       branch_fwd_a,
    input  logic [1:0]       branch_fwd_b,
    input  logic             idex_reg_write,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_mem_read,
    input  logic [4:0]       exmem_rd,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_target,
    output logic             if_flush
);

    state_t             state_reg, state_next;
    logic [STALL_W-1:0] cnt_reg, cnt_next;

    logic [WIDTH-1:0]   ifid_instr_reg;
    logic [WIDTH-1:0]   ifid_pc_plus4_reg;

    logic [5:0]         opcode;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic               is_beq;
    logic               is_bne;
    logic               is_branch;

    logic               hazard;
    logic [STALL_W-1:0] haz_count;
    logic               stall;
    logic               resolve;
    logic               cmp_taken;

    // ---------------------------------------------------------------- decode
    assign opcode    = ifid_instr_reg[31:26];
    assign rs        = ifid_instr_reg[25:21];
    assign rt        = ifid_instr_reg[20:16];
    assign is_beq    = (opcode == OP_BEQ);
    assign is_bne    = (opcode == OP_BNE);
    assign is_branch = is_beq || is_bne;

    // ------------------------------------------------------- hazard detection
    // An ALU result in ID/EX is forwardable from EX/MEM one cycle later; a load
    // in ID/EX only reaches MEM/WB two cycles later. A load already in EX/MEM
    // needs one more cycle.
    always_comb begin
        hazard    = 1'b0;
        haz_count = '0;
        if (idex_reg_write && reg_match(idex_rd, rs, rt)) begin
            hazard    = 1'b1;
            haz_count = idex_mem_read ? STALL_W'(2) : STALL_W'(1);
        end else if (exmem_mem_read && reg_match(exmem_rd, rs, rt)) begin
            hazard    = 1'b1;
            haz_count = STALL_W'(1);
        end
    end

    // -------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The IDLE cycle that detects the hazard is itself the first stall cycle,
    // so the counter is loaded with the remaining number of stall cycles.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        resolve    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (is_branch && hazard) begin
                    stall    = 1'b1;
                    cnt_next = haz_count - STALL_W'(1);
                    if (cnt_next != '0) begin
                        state_next = STALL;
                    end
                end else if (is_branch) begin
                    resolve = 1'b1;
                end
            end
            STALL: begin
                stall    = 1'b1;
                cnt_next = cnt_reg - STALL_W'(1);
                if (cnt_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // --------------------------------------------------------- resolution
    branch_compare #(
        .WIDTH(WIDTH)
    ) u_branch_compare (
        .fwd_a            (branch_fwd_a),
        .fwd_b            (branch_fwd_b),
        .rf_rdata1        (rf_rdata1),
        .rf_rdata2        (rf_rdata2),
        .exmem_alu_result (exmem_alu_result),
        .memwb_wb_data    (memwb_wb_data),
        .is_bne           (is_bne),
        .pc_plus4         (ifid_pc_plus4_reg),
        .imm              (ifid_instr_reg[15:0]),
        .taken            (cmp_taken),
        .target           (branch_target)
    );

    assign branch_taken = resolve && cmp_taken;
    assign if_flush     = branch_taken;
    assign pc_write     = !stall;
    assign ifid_write   = !stall;
    assign idex_bubble  = stall;

    // ------------------------------------------------------ IF/ID register
    // Priority: hold while stalled, then squash on a taken branch, then load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr_reg    <= '0;
            ifid_pc_plus4_reg <= '0;
        end else if (!ifid_write) begin
            ifid_instr_reg    <= ifid_instr_reg;
            ifid_pc_plus4_reg <= ifid_pc_plus4_reg;
        end else if (if_flush) begin
            ifid_instr_reg    <= WIDTH'(NOP_INSTR);
            ifid_pc_plus4_reg <= if_pc_plus4;
        end else begin
            ifid_instr_reg    <= if_instr;
            ifid_pc_plus4_reg <= if_pc_plus4;
        end
    end

    assign ifid_instr    = ifid_instr_reg;
    assign ifid_pc_plus4 = ifid_pc_plus4_reg;

endmodule

// File: tb/tb_id_branch_unit.sv
module tb_id_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [31:0] exmem_alu_result;
    logic [31:0] memwb_wb_data;
    logic [1:0]  branch_fwd_a;
    logic [1:0]  branch_fwd_b;
    logic        idex_reg_write;
    logic        idex_mem_read;
    logic [4:0]  idex_rd;
    logic        exmem_mem_read;
    logic [4:0]  exmem_rd;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_flush;

    int total = 0;
    int bad   = 0;

    id_branch_unit #(.WIDTH(32), .STALL_W(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc_plus4      (if_pc_plus4),
        .if_instr         (if_instr),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_instr       (ifid_instr),
        .rf_rdata1        (rf_rdata1),
        .rf_rdata2        (rf_rdata2),
        .exmem_alu_result (exmem_alu_result),
        .memwb_wb_data    (memwb_wb_data),
        .branch_fwd_a     (branch_fwd_a),
        .branch_fwd_b     (branch_fwd_b),
        .idex_reg_write   (idex_reg_write),
        .idex_mem_read    (idex_mem_read),
        .idex_rd          (idex_rd),
        .exmem_mem_read   (exmem_mem_read),
        .exmem_rd         (exmem_rd),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .idex_bubble      (idex_bubble),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .if_flush         (if_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-encoded instructions.
    localparam logic [31:0] BEQ_1_2_P4   = 32'h1022_0004; // beq $1,$2,+4
    localparam logic [31:0] BNE_3_0_M1   = 32'h1460_FFFF; // bne $3,$0,-1
    localparam logic [31:0] BEQ_4_5_P8   = 32'h1085_0008; // beq $4,$5,+8
    localparam logic [31:0] BEQ_0_0_P2   = 32'h1000_0002; // beq $0,$0,+2
    localparam logic [31:0] ADD_5_3_4    = 32'h0064_2820; // add $5,$3,$4
    localparam logic [31:0] BEQ_1_2_P1   = 32'h1022_0001; // beq $1,$2,+1
    localparam logic [31:0] BEQ_6_5_M2   = 32'h10C5_FFFE; // beq $6,$5,-2
    localparam logic [31:0] FILLER       = 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_side();
        rf_rdata1        = 32'h0;
        rf_rdata2        = 32'h0;
        exmem_alu_result = 32'h0;
        memwb_wb_data    = 32'h0;
        branch_fwd_a     = 2'b00;
        branch_fwd_b     = 2'b00;
        idex_reg_write   = 1'b0;
        idex_mem_read    = 1'b0;
        idex_rd          = 5'd0;
        exmem_mem_read   = 1'b0;
        exmem_rd         = 5'd0;
    endtask

    // Drain ID to a NOP first so the load edge is neither flushed nor held.
    task automatic load_instr(input logic [31:0] pc4, input logic [31:0] instr);
        clear_side();
        if_instr    = 32'h0;
        if_pc_plus4 = 32'h0;
        tick();
        if_instr    = instr;
        if_pc_plus4 = pc4;
        tick();
        if_instr    = FILLER;
        if_pc_plus4 = pc4 + 32'd4;
    endtask

    task automatic test_reset();
        load_instr(32'h0000_0040, BEQ_1_2_P4);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ifid_instr !== 32'h0) begin
            bad++; $display("FAIL reset_instr got=%h want=%h", ifid_instr, 32'h0);
        end
        total++;
        if (ifid_pc_plus4 !== 32'h0) begin
            bad++; $display("FAIL reset_pc4 got=%h want=%h", ifid_pc_plus4, 32'h0);
        end
        total++;
        if ({pc_write, ifid_write, idex_bubble, branch_taken, if_flush} !== 5'b11000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=%b",
                            {pc_write, ifid_write, idex_bubble, branch_taken, if_flush}, 5'b11000);
        end
        total++;
        if (branch_target !== 32'h0) begin
            bad++; $display("FAIL reset_target got=%h want=%h", branch_target, 32'h0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_beq_taken();
        load_instr(32'h0000_0100, BEQ_1_2_P4);
        rf_rdata1 = 32'h55; rf_rdata2 = 32'h55;
        #1;
        total++;
        if ({branch_taken, if_flush, pc_write} !== 3'b111) begin
            bad++; $display("FAIL beq_taken_ctrl got=%b want=%b", {branch_taken, if_flush, pc_write}, 3'b111);
        end
        total++;
        if (branch_target !== 32'h0000_0110) begin
            bad++; $display("FAIL beq_target got=%h want=%h", branch_target, 32'h110);
        end
        tick();
        total++;
        if (ifid_instr !== 32'h0) begin
            bad++; $display("FAIL beq_flush_instr got=%h want=%h", ifid_instr, 32'h0);
        end
        total++;
        if (ifid_pc_plus4 !== 32'h0000_0104) begin
            bad++; $display("FAIL beq_flush_pc4 got=%h want=%h", ifid_pc_plus4, 32'h104);
        end
        $display("test_beq_taken done");
    endtask

    task automatic test_beq_not_taken();
        load_instr(32'h0000_0100, BEQ_1_2_P4);
        rf_rdata1 = 32'h55; rf_rdata2 = 32'h56;
        #1;
        total++;
        if ({branch_taken, if_flush} !== 2'b00) begin
            bad++; $display("FAIL beq_nt_ctrl got=%b want=%b", {branch_taken, if_flush}, 2'b00);
        end
        tick();
        total++;
        if (ifid_instr !== FILLER) begin
            bad++; $display("FAIL beq_nt_load got=%h want=%h", ifid_instr, FILLER);
        end
        $display("test_beq_not_taken done");
    endtask

    task automatic test_bne_after_alu();
        load_instr(32'h0000_0200, BNE_3_0_M1);
        idex_reg_write = 1'b1; idex_rd = 5'd3; idex_mem_read = 1'b0;
        #1;
        total++;
        if ({pc_write, ifid_write, idex_bubble, branch_taken} !== 4'b0010) begin
            bad++; $display("FAIL alu_stall got=%b want=%b",
                            {pc_write, ifid_write, idex_bubble, branch_taken}, 4'b0010);
        end
        tick();
        clear_side();
        exmem_alu_result = 32'd5; exmem_rd = 5'd3; branch_fwd_a = 2'b01;
        #1;
        total++;
        if (ifid_instr !== BNE_3_0_M1) begin
            bad++; $display("FAIL alu_hold got=%h want=%h", ifid_instr, BNE_3_0_M1);
        end
        total++;
        if ({pc_write, idex_bubble, branch_taken, if_flush} !== 4'b1011) begin
            bad++; $display("FAIL alu_resolve got=%b want=%b",
                            {pc_write, idex_bubble, branch_taken, if_flush}, 4'b1011);
        end
        total++;
        if (branch_target !== 32'h0000_01FC) begin
            bad++; $display("FAIL alu_target got=%h want=%h", branch_target, 32'h1FC);
        end
        tick();
        $display("test_bne_after_alu done");
    endtask

    task automatic test_beq_after_load();
        load_instr(32'h0000_0300, BEQ_4_5_P8);
        idex_reg_write = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd4;
        #1;
        total++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
            bad++; $display("FAIL load_stall1 got=%b want=%b", {pc_write, ifid_write, idex_bubble}, 3'b001);
        end
        tick();
        clear_side();
        exmem_mem_read = 1'b1; exmem_rd = 5'd4;
        #1;
        total++;
        if ({pc_write, ifid_write, idex_bubble, branch_taken} !== 4'b0010) begin
            bad++; $display("FAIL load_stall2 got=%b want=%b",
                            {pc_write, ifid_write, idex_bubble, branch_taken}, 4'b0010);
        end
        tick();
        clear_side();
        memwb_wb_data = 32'd7; rf_rdata2 = 32'd7; branch_fwd_a = 2'b10;
        #1;
        total++;
        if (ifid_instr !== BEQ_4_5_P8) begin
            bad++; $display("FAIL load_hold got=%h want=%h", ifid_instr, BEQ_4_5_P8);
        end
        total++;
        if ({pc_write, idex_bubble, branch_taken} !== 3'b101) begin
            bad++; $display("FAIL load_resolve got=%b want=%b", {pc_write, idex_bubble, branch_taken}, 3'b101);
        end
        total++;
        if (branch_target !== 32'h0000_0320) begin
            bad++; $display("FAIL load_target got=%h want=%h", branch_target, 32'h320);
        end
        tick();
        $display("test_beq_after_load done");
    endtask

    task automatic test_exmem_load();
        load_instr(32'h0000_0400, BEQ_6_5_M2);
        exmem_mem_read = 1'b1; exmem_rd = 5'd5;
        #1;
        total++;
        if ({pc_write, idex_bubble} !== 2'b01) begin
            bad++; $display("FAIL exmem_stall got=%b want=%b", {pc_write, idex_bubble}, 2'b01);
        end
        tick();
        clear_side();
        memwb_wb_data = 32'd9; rf_rdata1 = 32'd9; branch_fwd_b = 2'b10;
        #1;
        total++;
        if ({pc_write, branch_taken} !== 2'b11) begin
            bad++; $display("FAIL exmem_resolve got=%b want=%b", {pc_write, branch_taken}, 2'b11);
        end
        total++;
        if (branch_target !== 32'h0000_03F8) begin
            bad++; $display("FAIL exmem_target got=%h want=%h", branch_target, 32'h3F8);
        end
        tick();
        $display("test_exmem_load done");
    endtask

    task automatic test_reg0_and_nonbranch();
        load_instr(32'h0000_0500, BEQ_0_0_P2);
        idex_reg_write = 1'b1; idex_rd = 5'd0; idex_mem_read = 1'b1;
        #1;
        total++;
        if ({pc_write, idex_bubble, branch_taken} !== 3'b101) begin
            bad++; $display("FAIL reg0 got=%b want=%b", {pc_write, idex_bubble, branch_taken}, 3'b101);
        end
        load_instr(32'h0000_0600, ADD_5_3_4);
        idex_reg_write = 1'b1; idex_rd = 5'd3; idex_mem_read = 1'b1;
        #1;
        total++;
        if ({pc_write, idex_bubble, branch_taken, if_flush} !== 4'b1000) begin
            bad++; $display("FAIL nonbranch got=%b want=%b",
                            {pc_write, idex_bubble, branch_taken, if_flush}, 4'b1000);
        end
        $display("test_reg0_and_nonbranch done");
    endtask

    task automatic test_target_wrap();
        load_instr(32'hFFFF_FFFC, BEQ_1_2_P1);
        rf_rdata1 = 32'd1; rf_rdata2 = 32'd2;
        #1;
        total++;
        if (branch_target !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap_target got=%h want=%h", branch_target, 32'h0);
        end
        $display("test_target_wrap done");
    endtask

    task automatic test_reset_mid_stall();
        load_instr(32'h0000_0700, BEQ_4_5_P8);
        idex_reg_write = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd5;
        tick();
        clear_side();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ifid_instr, pc_write, idex_bubble} !== {32'h0, 2'b10}) begin
            bad++; $display("FAIL mid_stall_reset got=%h/%b want=%h/%b",
                            ifid_instr, {pc_write, idex_bubble}, 32'h0, 2'b10);
        end
        tick();
        rst_n = 1'b1;
        load_instr(32'h0000_0800, BEQ_1_2_P4);
        rf_rdata1 = 32'd3; rf_rdata2 = 32'd3;
        #1;
        total++;
        if ({pc_write, branch_taken} !== 2'b11) begin
            bad++; $display("FAIL post_reset_idle got=%b want=%b", {pc_write, branch_taken}, 2'b11);
        end
        $display("test_reset_mid_stall done");
    endtask

    initial begin
        rst_n       = 1'b0;
        if_instr    = 32'h0;
        if_pc_plus4 = 32'h0;
        clear_side();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_beq_taken();
        test_beq_not_taken();
        test_bne_after_alu();
        test_beq_after_load();
        test_exmem_load();
        test_reg0_and_nonbranch();
        test_target_wrap();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_branch_unit.md
# id_branch_unit

Decode-stage branch resolution for the 5-stage MIPS pipeline. It holds the IF/ID pipeline register, consumes the `branchFWDA`/`branchFWDB` selects from the branch forwarding detector, and muxes operands for `beq`/`bne`. It resolves the branch in ID and drives PC redirect, IF flush, and the stall/bubble controls for branches that depend on in-flight results that cannot yet be forwarded.

## Interface
Parameters:
- `WIDTH`, 32, datapath and PC width.
- `STALL_W`, 2, stall counter width.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `if_pc_plus4`  in  WIDTH  — PC+4 from IF.
- `if_instr`  in  WIDTH  — fetched instruction.
- `ifid_pc_plus4`  out  WIDTH  — registered IF/ID PC+4.
- `ifid_instr`  out  WIDTH  — registered IF/ID instruction; `rs` = [25:21], `rt` = [20:16].
- `rf_rdata1`, `rf_rdata2`  in  WIDTH  — register file reads of `rs`/`rt`.
- `exmem_alu_result`  in  WIDTH  — EX/MEM forward source.
- `memwb_wb_data`  in  WIDTH  — MEM/WB forward source.
- `branch_fwd_a`, `branch_fwd_b`  in  2  — operand selects: 00 = RF, 01 = EX/MEM, 10 = MEM/WB; 11 is treated as RF.
- `idex_reg_write`, `idex_mem_read`  in  1  — ID/EX producer flags.
- `idex_rd`  in  5  — ID/EX destination register.
- `exmem_mem_read`  in  1  — EX/MEM load flag.
- `exmem_rd`  in  5  — EX/MEM destination register.
- `pc_write`  out  1  — PC register enable.
- `ifid_write`  out  1  — IF/ID register enable (exported for visibility).
- `idex_bubble`  out  1  — zero the ID/EX control fields this cycle.
- `branch_taken`  out  1  — PC mux select: 1 selects the branch target.
- `branch_target`  out  WIDTH  — branch target address.
- `if_flush`  out  1  — the fall-through instruction is being squashed.

## Operation
- Decode: the ID instruction is a branch when `ifid_instr[31:26]` is 000100 (`beq`) or 000101 (`bne`); every other opcode is a non-branch. Both `rs` and `rt` are used.
- Hazard detection, evaluated only in IDLE when a branch is in ID. A register *matches* when it is nonzero and equals `rs` or `rt`.
  - If `idex_reg_write` and `idex_rd` matches: load count 2 if `idex_mem_read`, else count 1.
  - Otherwise, if `exmem_mem_read` and `exmem_rd` matches: load count 1.
  - Otherwise there is no hazard.
- FSM states:
  - **IDLE**: with a hazard, assert stall outputs, load the counter with (count − 1), and go to STALL if that value is nonzero. A count of 1 stays in IDLE for the next cycle. With no hazard, resolve the branch.
  - **STALL**: assert stall outputs and decrement. Go to IDLE when the counter reaches 0; hazard detection is not re-evaluated in STALL.
- Stall outputs: `pc_write` = 0, `ifid_write` = 0, `idex_bubble` = 1. All other cycles: 1 / 1 / 0.
- Resolve:
  - Operand A = mux(`branch_fwd_a`); operand B = mux(`branch_fwd_b`).
  - `eq` = (A == B); taken = `beq` ? `eq` : !`eq`.
  - `branch_target` = `ifid_pc_plus4` + ({{14{imm[15]}}, imm[15:0], 2'b00}), modulo 2^WIDTH (wraps silently).
- Flush: when `branch_taken` = 1, `if_flush` = 1. At the same edge IF/ID loads NOP (32'h0) instead of `if_instr`, and `ifid_pc_plus4` loads `if_pc_plus4`.
- IF/ID update priority per edge: hold (`ifid_write` = 0) > flush > normal load.

## Timing
- Reset (asynchronous, `rst_n` = 0): `ifid_instr` = 0, `ifid_pc_plus4` = 0, state IDLE, counter 0.
  - Outputs during and after reset: `pc_write` = 1, `ifid_write` = 1, `idex_bubble` = 0, `branch_taken` = 0, `if_flush` = 0.
  - `branch_target` = 0 + sext(0) = 0.
- Control outputs are combinational from state, IF/ID contents, and the hazard inputs. The IF/ID register has a latency of 1 cycle.
- Branch-after-ALU takes 1 stall cycle, then resolves with forward select 01.
- Branch-after-load takes 2 stall cycles, then resolves with forward select 10.
- Load in EX/MEM takes 1 stall cycle.
- Stall and flush never coincide: a branch resolves only in IDLE with no hazard.
- A non-branch in ID never stalls, even when the register indices match.
- Reset asserted mid-STALL returns immediately to IDLE with IF/ID cleared; the stalled branch is lost by design.

## Structure
- Shared package `mips_pkg`:
  - opcodes `OP_BEQ`, `OP_BNE`;
  - forward-select constants `FWD_RF` = 00, `FWD_EXMEM` = 01, `FWD_MEMWB` = 10;
  - `NOP_INSTR` = 32'h0;
  - state encoding `IDLE` / `STALL`.
- Sub-module `branch_compare`: combinational operand muxes, equality test, `beq`/`bne` decision, and target adder.
- The top level holds the FSM, the counter, and the IF/ID register.

## Test plan
- **Reset**: `rst_n` low mid-run. Required: `ifid_instr` = 0, `pc_write` = 1, `branch_taken` = 0 within the same cycle.
- **beq taken, no hazard**: `beq` $1,$2,+4 at PC+4 = 0x100, RF values equal, selects 00. Required: `branch_taken` = 1, `branch_target` = 0x110, next `ifid_instr` = 0.
- **bne after ALU write**: producer in ID/EX writes $3 (not a load) before `bne` $3,$0. Required: 1 cycle with `pc_write` = 0 and `idex_bubble` = 1; next cycle resolves using `exmem_alu_result` (select 01) = 5, so taken = 1.
- **beq after load**: `idex_mem_read` = 1, `idex_rd` = 4 before `beq` $4,$5. Required: exactly 2 stall cycles with IF/ID held; third cycle uses select 10 with `memwb_wb_data` = 7 and `rf_rdata2` = 7, so taken = 1.
- **Register $0 and non-branch**: `idex_rd` = 0 with a `beq` $0,$0 gives no stall and taken = 1. An `add` in ID with matching `rs` gives no stall.
- **Target wrap**: `ifid_pc_plus4` = 0xFFFF_FFFC, imm = 1. Required: `branch_target` = 0x0000_0000.
